// File: rtl/loop_mix_accum.sv
// Per-frame stereo mixer: sums aux plus one word per playing bank, saturates to DATA_W.
// Also reports banks that never delivered and flags duplicate deliveries.
module loop_mix_accum #(
    parameter int NUM_BANKS = 16,
    parameter int BANK_W    = 4,
    parameter int DATA_W    = 24,
    parameter int ACC_W     = 29
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 frame_start,
    input  logic [NUM_BANKS-1:0] playing,
    input  logic [DATA_W-1:0]    aux_l,
    input  logic [DATA_W-1:0]    aux_r,
    input  logic                 word_valid,
    input  logic [BANK_W-1:0]    bank_idx,
    input  logic [63:0]          word,
    input  logic                 frame_end,
    output logic [DATA_W-1:0]    mix_l,
    output logic [DATA_W-1:0]    mix_r,
    output logic                 mix_valid,
    output logic [NUM_BANKS-1:0] missing,
    output logic                 dup_err,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, SAT, OUT} state_t;

    state_t state, state_nxt;

    logic [NUM_BANKS-1:0] pmask, rcvd, sel, take;
    logic [ACC_W-1:0]     acc_l, acc_r;
    logic                 accept, dup, complete;
    logic                 unused;

    function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // In range only when every bit above the sign position matches the sign.
    function automatic logic [DATA_W-1:0] sat(input logic [ACC_W-1:0] a);
        logic [ACC_W-DATA_W:0] top;
        top = a[ACC_W-1:DATA_W-1];
        if (top == '0 || top == '1)
            return a[DATA_W-1:0];
        else if (a[ACC_W-1])
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    assign unused = ^word[63:2*DATA_W];

    // Out-of-range indices match no bit, so they behave as non-playing.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_BANKS; i++)
            sel[i] = word_valid && (bank_idx == BANK_W'(i));
    end

    assign take     = sel & pmask & ~rcvd;
    assign accept   = |take;
    assign dup      = |(sel & rcvd);
    assign complete = ((rcvd | take) == pmask) || frame_end || frame_start;

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (frame_start) state_nxt = ACCUM;
            ACCUM: if (complete)    state_nxt = SAT;
            SAT:   state_nxt = OUT;
            OUT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mix_valid = (state == OUT);
        busy      = (state == ACCUM) || (state == SAT);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_l   <= '0;
            acc_r   <= '0;
            pmask   <= '0;
            rcvd    <= '0;
            mix_l   <= '0;
            mix_r   <= '0;
            missing <= '0;
            dup_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        acc_l <= sext(aux_l);
                        acc_r <= sext(aux_r);
                        pmask <= playing;
                        rcvd  <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_l <= acc_l + sext(word[2*DATA_W-1:DATA_W]);
                        acc_r <= acc_r + sext(word[DATA_W-1:0]);
                        rcvd  <= rcvd | take;
                    end
                    if (dup)
                        dup_err <= 1'b1;
                end
                SAT: begin
                    mix_l   <= sat(acc_l);
                    mix_r   <= sat(acc_r);
                    missing <= pmask & ~rcvd;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_loop_mix_accum.sv
// Directed bench for loop_mix_accum with hand-computed mixes.
module tb_loop_mix_accum;

    logic        clk = 1'b0;
    logic        rstn;
    logic        frame_start;
    logic [15:0] playing;
    logic [23:0] aux_l, aux_r;
    logic        word_valid;
    logic [3:0]  bank_idx;
    logic [63:0] word;
    logic        frame_end;
    logic [23:0] mix_l, mix_r;
    logic        mix_valid;
    logic [15:0] missing;
    logic        dup_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    loop_mix_accum dut (
        .clk(clk), .rstn(rstn), .frame_start(frame_start),
        .playing(playing), .aux_l(aux_l), .aux_r(aux_r),
        .word_valid(word_valid), .bank_idx(bank_idx), .word(word),
        .frame_end(frame_end), .mix_l(mix_l), .mix_r(mix_r),
        .mix_valid(mix_valid), .missing(missing), .dup_err(dup_err),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] pl, input logic [23:0] al,
                               input logic [23:0] ar);
        frame_start = 1'b1;
        playing = pl;
        aux_l = al;
        aux_r = ar;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send(input logic [3:0] b, input logic [23:0] l,
                        input logic [23:0] r);
        word_valid = 1'b1;
        bank_idx = b;
        word = {16'hDEAD, l, r};
        tick();
        word_valid = 1'b0;
    endtask

    task automatic end_frame;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic wait_mix(input string tag, input int lat);
        int n = 0;
        while (!mix_valid && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(n), 64'(lat));
    endtask

    initial begin
        int seen;
        rstn = 1'b0;
        frame_start = 1'b0;
        playing = '0;
        aux_l = '0;
        aux_r = '0;
        word_valid = 1'b0;
        bank_idx = '0;
        word = '0;
        frame_end = 1'b0;
        tick();
        tick();
        rstn = 1'b1;

        check("rst_mix_l", 64'(mix_l), 0);
        check("rst_mix_r", 64'(mix_r), 0);
        check("rst_valid", 64'(mix_valid), 0);
        check("rst_missing", 64'(missing), 0);
        check("rst_dup", 64'(dup_err), 0);
        check("rst_busy", 64'(busy), 0);

        // aux only
        start_frame(16'h0000, 24'h000100, 24'hFFFF00);
        check("aux_busy", 64'(busy), 1);
        wait_mix("aux_lat", 2);
        check("aux_l", 64'(mix_l), 64'h000100);
        check("aux_r", 64'(mix_r), 64'hFFFF00);
        check("aux_missing", 64'(missing), 0);
        check("aux_busy_out", 64'(busy), 0);
        tick();
        check("aux_pulse", 64'(mix_valid), 0);
        check("aux_hold", 64'(mix_l), 64'h000100);
        tick();
        tick();

        // two banks
        start_frame(16'h0005, 24'h0, 24'h0);
        send(4'd0, 24'h100000, 24'h000010);
        check("two_busy", 64'(busy), 1);
        send(4'd2, 24'h200000, 24'hFFFFF0);
        wait_mix("two_lat", 1);
        check("two_l", 64'(mix_l), 64'h300000);
        check("two_r", 64'(mix_r), 64'h000000);
        check("two_dup", 64'(dup_err), 0);
        check("two_missing", 64'(missing), 0);
        tick();
        tick();
        tick();

        // full saturation with 16 banks
        start_frame(16'hFFFF, 24'h0, 24'h0);
        for (int i = 0; i < 16; i++)
            send(4'(i), 24'h7FFFFF, 24'h800000);
        wait_mix("sat_lat", 1);
        check("sat_l", 64'(mix_l), 64'h7FFFFF);
        check("sat_r", 64'(mix_r), 64'h800000);
        tick();
        tick();
        tick();

        // one past max clamps; exactly min passes through
        start_frame(16'h0001, 24'h7FFFFF, 24'h800001);
        send(4'd0, 24'h000001, 24'hFFFFFF);
        wait_mix("edge_lat", 1);
        check("edge_l", 64'(mix_l), 64'h7FFFFF);
        check("edge_r", 64'(mix_r), 64'h800000);
        tick();
        tick();
        tick();

        // missing bank, forced end
        start_frame(16'h0003, 24'h000005, 24'hFFFFFF);
        send(4'd1, 24'h001000, 24'h000002);
        check("miss_busy", 64'(busy), 1);
        end_frame();
        wait_mix("miss_lat", 1);
        check("miss_l", 64'(mix_l), 64'h001005);
        check("miss_r", 64'(mix_r), 64'h000001);
        check("miss_mask", 64'(missing), 64'h0001);
        tick();
        tick();
        tick();

        // frame_start during ACCUM ends the frame and is dropped
        start_frame(16'h0001, 24'h000042, 24'h000024);
        start_frame(16'hFFFF, 24'h000123, 24'h000123);
        wait_mix("fs_lat", 1);
        check("fs_l", 64'(mix_l), 64'h000042);
        check("fs_missing", 64'(missing), 64'h0001);
        tick();
        check("fs_dropped", 64'(busy), 0);
        tick();
        tick();

        // non-playing bank ignored, duplicate flagged
        start_frame(16'h0006, 24'h0, 24'h0);
        send(4'd3, 24'h111111, 24'h111111);
        check("np_dup", 64'(dup_err), 0);
        send(4'd1, 24'h000020, 24'h000030);
        send(4'd1, 24'h000400, 24'h000500);
        end_frame();
        wait_mix("dup_lat", 1);
        check("dup_l", 64'(mix_l), 64'h000020);
        check("dup_r", 64'(mix_r), 64'h000030);
        check("dup_flag", 64'(dup_err), 1);
        check("dup_missing", 64'(missing), 64'h0004);
        tick();
        tick();
        tick();
        start_frame(16'h0000, 24'h000007, 24'h000008);
        wait_mix("sticky_lat", 2);
        check("dup_sticky", 64'(dup_err), 1);
        check("sticky_l", 64'(mix_l), 64'h000007);
        tick();
        tick();
        tick();

        // reset mid-frame discards partial sum
        start_frame(16'h0003, 24'h0, 24'h0);
        send(4'd0, 24'h000400, 24'h000400);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mid_rst_l", 64'(mix_l), 0);
        check("mid_rst_r", 64'(mix_r), 0);
        check("mid_rst_busy", 64'(busy), 0);
        check("mid_rst_dup", 64'(dup_err), 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (mix_valid) seen++;
            tick();
        end
        check("mid_rst_novalid", 64'(seen), 0);
        start_frame(16'h0003, 24'h000001, 24'h000002);
        send(4'd0, 24'h000010, 24'h000020);
        send(4'd1, 24'h000100, 24'h000200);
        wait_mix("post_lat", 1);
        check("post_l", 64'(mix_l), 64'h000111);
        check("post_r", 64'(mix_r), 64'h000222);
        check("post_missing", 64'(missing), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
